// File: rtl/minimac3_rxslots.sv
// Receive-slot engine: streams received bytes into one of SLOTS RAM slots and tracks per-slot state/length.
// Optional drop counter enabled by defining MINIMAC3_RXSLOTS_DROP_COUNT_EN.
module minimac3_rxslots #(
  parameter int unsigned SLOT_BITS = 2,
  parameter int unsigned SLOT_AW   = 11
) (
  input  logic                         sys_clk,
  input  logic                         sys_rst,
  input  logic                         rx_stb,
  input  logic [7:0]                   rx_dat,
  input  logic                         rx_eof,
  input  logic                         rx_err,
  output logic                         mem_we,
  output logic [SLOT_BITS+SLOT_AW-1:0] mem_adr,
  output logic [7:0]                   mem_dat,
  input  logic                         arm_stb,
  input  logic [SLOT_BITS-1:0]         arm_slot,
  output logic [(2**SLOT_BITS)-1:0]    done_mask,
  input  logic [SLOT_BITS-1:0]         len_sel,
  output logic [SLOT_AW:0]             len_do,
  output logic                         busy,
  output logic                         irq,
  input  logic                         drop_clr,
  output logic [15:0]                  drop_count
);

  localparam int unsigned SLOTS = 2**SLOT_BITS;
  localparam int unsigned CW    = SLOT_AW + 1;
  localparam logic [CW-1:0] MAX_CNT = CW'(2**SLOT_AW);

  typedef enum logic [1:0] {S_EMPTY, S_READY, S_FILLING, S_DONE} slot_t;
  typedef enum logic [1:0] {E_IDLE, E_RECV, E_DISCARD} eng_t;

  slot_t                slot_st  [SLOTS];
  logic [CW-1:0]        slot_len [SLOTS];
  eng_t                 eng;
  logic [SLOT_BITS-1:0] cur;
  logic [CW-1:0]        cnt;

  logic                 free_vld;
  logic [SLOT_BITS-1:0] free_idx;
  logic                 drop;

  // lowest-index READY slot
  always_comb begin
    free_vld = 1'b0;
    free_idx = '0;
    for (int i = 0; i < SLOTS; i++) begin
      if (!free_vld && slot_st[i] == S_READY) begin
        free_vld = 1'b1;
        free_idx = SLOT_BITS'(i);
      end
    end
  end

  always_comb begin
    drop = 1'b0;
    case (eng)
      E_IDLE:  drop = rx_stb && !free_vld;
      E_RECV:  drop = rx_err || (!rx_eof && rx_stb && cnt == MAX_CNT);
      default: drop = 1'b0;
    endcase
  end

  assign len_do = slot_len[len_sel];

  // arm requests are applied first so that a same-cycle engine update on that slot overrides them
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      for (int i = 0; i < SLOTS; i++) begin
        slot_st[i]  <= S_EMPTY;
        slot_len[i] <= '0;
      end
      eng       <= E_IDLE;
      cur       <= '0;
      cnt       <= '0;
      mem_we    <= 1'b0;
      mem_adr   <= '0;
      mem_dat   <= '0;
      busy      <= 1'b0;
      done_mask <= '0;
      irq       <= 1'b0;
    end else begin
      mem_we <= 1'b0;
      if (arm_stb && (slot_st[arm_slot] == S_EMPTY || slot_st[arm_slot] == S_DONE))
        slot_st[arm_slot] <= S_READY;

      case (eng)
        E_IDLE: begin
          if (rx_stb) begin
            if (free_vld) begin
              slot_st[free_idx] <= S_FILLING;
              cur     <= free_idx;
              mem_we  <= 1'b1;
              mem_adr <= {free_idx, SLOT_AW'(0)};
              mem_dat <= rx_dat;
              cnt     <= CW'(1);
              busy    <= 1'b1;
              eng     <= E_RECV;
            end else begin
              eng <= E_DISCARD;
            end
          end
        end
        E_RECV: begin
          if (rx_err) begin
            slot_st[cur] <= S_READY;
            cnt  <= '0;
            busy <= 1'b0;
            eng  <= E_IDLE;
          end else if (rx_eof) begin
            slot_st[cur]  <= S_DONE;
            slot_len[cur] <= cnt;
            cnt  <= '0;
            busy <= 1'b0;
            eng  <= E_IDLE;
          end else if (rx_stb) begin
            if (cnt == MAX_CNT) begin
              // overflow: give the slot back and swallow the rest of the frame
              slot_st[cur] <= S_READY;
              cnt  <= '0;
              busy <= 1'b0;
              eng  <= E_DISCARD;
            end else begin
              mem_we  <= 1'b1;
              mem_adr <= {cur, cnt[SLOT_AW-1:0]};
              mem_dat <= rx_dat;
              cnt     <= cnt + CW'(1);
            end
          end
        end
        E_DISCARD: begin
          if (rx_eof || rx_err)
            eng <= E_IDLE;
        end
        default: eng <= E_IDLE;
      endcase

      for (int i = 0; i < SLOTS; i++)
        done_mask[i] <= (slot_st[i] == S_DONE);
      irq <= |done_mask;
    end
  end

`ifdef MINIMAC3_RXSLOTS_DROP_COUNT_EN
  // saturating drop counter, clear has priority
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst)
      drop_count <= '0;
    else if (drop_clr)
      drop_count <= '0;
    else if (drop && drop_count != 16'hFFFF)
      drop_count <= drop_count + 16'd1;
  end
`else
  logic unused_drop;
  assign unused_drop = drop ^ drop_clr;
  assign drop_count  = '0;
`endif

endmodule

// File: tb/tb_minimac3_rxslots.sv
// Directed bench for minimac3_rxslots at default parameters (4 slots, 2048-byte slots).
module tb_minimac3_rxslots;

  localparam int AW = 11;
`ifdef MINIMAC3_RXSLOTS_DROP_COUNT_EN
  localparam bit DC = 1'b1;
`else
  localparam bit DC = 1'b0;
`endif

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic        rx_stb = 1'b0, rx_eof = 1'b0, rx_err = 1'b0;
  logic [7:0]  rx_dat = '0;
  logic        mem_we;
  logic [12:0] mem_adr;
  logic [7:0]  mem_dat;
  logic        arm_stb = 1'b0;
  logic [1:0]  arm_slot = '0;
  logic [3:0]  done_mask;
  logic [1:0]  len_sel = '0;
  logic [11:0] len_do;
  logic        busy, irq;
  logic        drop_clr = 1'b0;
  logic [15:0] drop_count;

  int nvec = 0;
  int nerr = 0;
  logic [12:0] wa[$];
  logic [7:0]  wd[$];

  minimac3_rxslots #(.SLOT_BITS(2), .SLOT_AW(AW)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .rx_stb(rx_stb), .rx_dat(rx_dat), .rx_eof(rx_eof), .rx_err(rx_err),
    .mem_we(mem_we), .mem_adr(mem_adr), .mem_dat(mem_dat),
    .arm_stb(arm_stb), .arm_slot(arm_slot), .done_mask(done_mask),
    .len_sel(len_sel), .len_do(len_do), .busy(busy), .irq(irq),
    .drop_clr(drop_clr), .drop_count(drop_count)
  );

  always #5 sys_clk = ~sys_clk;

  // record every RAM write
  always @(negedge sys_clk) begin
    if (!sys_rst && mem_we) begin
      wa.push_back(mem_adr);
      wd.push_back(mem_dat);
    end
  end

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    sys_rst = 1'b1;
    tick();
    tick();
    sys_rst = 1'b0;
    tick();
  endtask

  task automatic arm(input logic [1:0] s);
    arm_stb = 1'b1;
    arm_slot = s;
    tick();
    arm_stb = 1'b0;
  endtask

  task automatic send_bytes(input int n, input int base);
    for (int i = 0; i < n; i++) begin
      rx_stb = 1'b1;
      rx_dat = 8'(base + i);
      tick();
    end
    rx_stb = 1'b0;
  endtask

  task automatic send_eof();
    rx_eof = 1'b1;
    tick();
    rx_eof = 1'b0;
  endtask

  task automatic read_len(input logic [1:0] s, input int exp, input string tag);
    len_sel = s;
    #1;
    chk(tag, 32'(len_do), 32'(exp));
  endtask

  initial begin
    // reset state
    tick();
    tick();
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_adr", 32'(mem_adr), 32'd0);
    chk("rst_done_mask", 32'(done_mask), 32'd0);
    chk("rst_irq", 32'(irq), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_drop", 32'(drop_count), 32'd0);
    chk("rst_len", 32'(len_do), 32'd0);
    sys_rst = 1'b0;
    tick();

    // 64-byte frame into slot 0
    arm(2'd0);
    arm(2'd1);
    wa.delete(); wd.delete();
    send_bytes(1, 8'h5A);
    chk("f64_busy", 32'(busy), 32'd1);
    send_bytes(63, 8'h5B);
    send_eof();
    chk("f64_busy_after", 32'(busy), 32'd0);
    chk("f64_mask_lag", 32'(done_mask), 32'd0);
    tick();
    chk("f64_mask", 32'(done_mask), 32'b0001);
    chk("f64_irq_lag", 32'(irq), 32'd0);
    tick();
    chk("f64_irq", 32'(irq), 32'd1);
    chk("f64_nwr", 32'(wa.size()), 32'd64);
    for (int i = 0; i < 64 && i < wa.size(); i++) begin
      chk($sformatf("f64_adr%0d", i), 32'(wa[i]), 32'(i));
      chk($sformatf("f64_dat%0d", i), 32'(wd[i]), 32'((8'h5A + i) & 8'hFF));
    end
    read_len(2'd0, 64, "f64_len");
    chk("f64_drop", 32'(drop_count), 32'd0);

    // no slot armed: frame dropped
    do_reset();
    wa.delete(); wd.delete();
    send_bytes(10, 8'h10);
    chk("noslot_busy", 32'(busy), 32'd0);
    send_eof();
    tick();
    tick();
    chk("noslot_nwr", 32'(wa.size()), 32'd0);
    chk("noslot_mask", 32'(done_mask), 32'd0);
    chk("noslot_irq", 32'(irq), 32'd0);
    chk("noslot_drop", 32'(drop_count), DC ? 32'd1 : 32'd0);

    // aborted frame returns slot 1 to READY, retry lands there
    arm(2'd1);
    wa.delete(); wd.delete();
    send_bytes(5, 8'h20);
    rx_err = 1'b1;
    tick();
    rx_err = 1'b0;
    tick();
    tick();
    chk("err_nwr", 32'(wa.size()), 32'd5);
    if (wa.size() > 0) chk("err_adr0", 32'(wa[0]), 32'((1 << AW) + 0));
    chk("err_mask", 32'(done_mask), 32'd0);
    chk("err_drop", 32'(drop_count), DC ? 32'd2 : 32'd0);
    wa.delete(); wd.delete();
    send_bytes(3, 8'h30);
    send_eof();
    tick();
    tick();
    chk("retry_nwr", 32'(wa.size()), 32'd3);
    if (wa.size() == 3) begin
      chk("retry_adr2", 32'(wa[2]), 32'((1 << AW) + 2));
      chk("retry_dat2", 32'(wd[2]), 32'h32);
    end
    chk("retry_mask", 32'(done_mask), 32'b0010);
    read_len(2'd1, 3, "retry_len");

    // overflow in slot 2: 2049 bytes, only 2048 written
    arm(2'd2);
    wa.delete(); wd.delete();
    send_bytes(2049, 0);
    chk("ovf_busy", 32'(busy), 32'd0);
    send_bytes(3, 8'h77);
    send_eof();
    tick();
    tick();
    chk("ovf_nwr", 32'(wa.size()), 32'd2048);
    if (wa.size() > 0) begin
      chk("ovf_first", 32'(wa[0]), 32'(2 << AW));
      chk("ovf_last", 32'(wa[wa.size() - 1]), 32'((2 << AW) + 2047));
      chk("ovf_lastdat", 32'(wd[wd.size() - 1]), 32'hFF);
    end
    chk("ovf_mask", 32'(done_mask), 32'b0010);
    chk("ovf_drop", 32'(drop_count), DC ? 32'd3 : 32'd0);
    wa.delete(); wd.delete();
    send_bytes(2, 8'h40);
    send_eof();
    tick();
    tick();
    chk("ovf_reuse_nwr", 32'(wa.size()), 32'd2);
    chk("ovf_reuse_mask", 32'(done_mask), 32'b0110);
    read_len(2'd2, 2, "ovf_reuse_len");
    drop_clr = 1'b1;
    tick();
    drop_clr = 1'b0;
    chk("drop_clr", 32'(drop_count), 32'd0);

    // four back-to-back frames of 1..4 bytes
    do_reset();
    for (int s = 0; s < 4; s++) arm(2'(s));
    wa.delete(); wd.delete();
    for (int k = 0; k < 4; k++) begin
      send_bytes(k + 1, 16 * k);
      send_eof();
    end
    tick();
    tick();
    chk("b2b_mask", 32'(done_mask), 32'b1111);
    chk("b2b_irq", 32'(irq), 32'd1);
    chk("b2b_nwr", 32'(wa.size()), 32'd10);
    if (wa.size() == 10) begin
      for (int k = 0, n = 0; k < 4; k++) begin
        for (int j = 0; j <= k; j++, n++) begin
          chk($sformatf("b2b_adr%0d", n), 32'(wa[n]), 32'((k << AW) + j));
          chk($sformatf("b2b_dat%0d", n), 32'(wd[n]), 32'(16 * k + j));
        end
      end
    end
    for (int k = 0; k < 4; k++) read_len(2'(k), k + 1, $sformatf("b2b_len%0d", k));

    // reset asserted while byte 20 of a frame is on the wire
    do_reset();
    arm(2'd0);
    wa.delete(); wd.delete();
    send_bytes(19, 0);
    rx_stb = 1'b1;
    rx_dat = 8'd19;
    sys_rst = 1'b1;
    #1;
    chk("mid_rst_we", 32'(mem_we), 32'd0);
    chk("mid_rst_adr", 32'(mem_adr), 32'd0);
    chk("mid_rst_dat", 32'(mem_dat), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_mask", 32'(done_mask), 32'd0);
    wa.delete(); wd.delete();
    tick();
    sys_rst = 1'b0;
    send_bytes(6, 8'd20);
    send_eof();
    tick();
    tick();
    chk("mid_rst_nwr", 32'(wa.size()), 32'd0);
    chk("mid_rst_mask2", 32'(done_mask), 32'd0);
    chk("mid_rst_irq", 32'(irq), 32'd0);
    read_len(2'd0, 0, "mid_rst_len");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
